vga_sync_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_sync_gen.sv | 132 +++++++++++++
 tb/tb_vga_sync_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Brief    : 800x600@60 Hz raster timing constants shared by the VGA blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_H_VIS    = 800;
    localparam int c_H_FP     = 40;
    localparam int c_H_SYNC   = 128;
    localparam int c_H_BP     = 88;
    localparam int c_H_TOTAL  = c_H_VIS + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int c_V_VIS    = 600;
    localparam int c_V_FP     = 1;
    localparam int c_V_SYNC   = 4;
    localparam int c_V_BP     = 23;
    localparam int c_V_TOTAL  = c_V_VIS + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int c_ADDR_W   = 11;
    localparam bit c_SYNC_POL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module   : vga_axis_counter
// Brief    : One raster axis: wrapping counter plus sync/visible window decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CNT_W      = c_ADDR_W,
    parameter int TOTAL      = c_H_TOTAL,
    parameter int SYNC_START = c_H_VIS + c_H_FP,
    parameter int SYNC_END   = c_H_VIS + c_H_FP + c_H_SYNC - 1,
    parameter int VIS        = c_H_VIS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_vis
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == CNT_W'(TOTAL - 1));
    // wrap marks the edge on which this axis rolls over, so it can step the next axis
    assign wrap     = step && w_at_max;
    assign count    = r_count;
    assign in_sync  = (r_count >= CNT_W'(SYNC_START)) && (r_count <= CNT_W'(SYNC_END));
    assign in_vis   = (r_count < CNT_W'(VIS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (step) begin
            r_count <= w_at_max ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module   : vga_sync_gen
// Brief    : Free-running VGA raster generator (syncs, visible addresses,
//            ready and frame-start). Define VGA_SYNC_FRAME_CNT_EN to add the
//            8-bit Frame_Cnt_Sig output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VIS    = c_H_VIS,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_VIS    = c_V_VIS,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter bit SYNC_POL = c_SYNC_POL
) (
    input  logic                CLK,
    input  logic                RST,
    output logic                HSYNC_Sig,
    output logic                VSYNC_Sig,
    output logic [c_ADDR_W-1:0] Column_Addr_Sig,
    output logic [c_ADDR_W-1:0] Row_Addr_Sig,
    output logic                Ready_Sig,
    output logic                Frame_Start_Sig
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0]          Frame_Cnt_Sig
`endif
);

    localparam int c_H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic [c_ADDR_W-1:0] w_h_cnt;
    logic [c_ADDR_W-1:0] w_v_cnt;
    logic                w_h_wrap;
    logic                w_v_wrap;
    logic                w_h_sync;
    logic                w_v_sync;
    logic                w_h_vis;
    logic                w_v_vis;
    logic                w_vis;
    logic                r_at_origin;

    vga_axis_counter #(
        .CNT_W      (c_ADDR_W),
        .TOTAL      (c_H_TOTAL),
        .SYNC_START (H_VIS + H_FP),
        .SYNC_END   (H_VIS + H_FP + H_SYNC - 1),
        .VIS        (H_VIS)
    ) u_h_axis (
        .clk     (CLK),
        .rst     (RST),
        .step    (1'b1),
        .count   (w_h_cnt),
        .wrap    (w_h_wrap),
        .in_sync (w_h_sync),
        .in_vis  (w_h_vis)
    );

    vga_axis_counter #(
        .CNT_W      (c_ADDR_W),
        .TOTAL      (c_V_TOTAL),
        .SYNC_START (V_VIS + V_FP),
        .SYNC_END   (V_VIS + V_FP + V_SYNC - 1),
        .VIS        (V_VIS)
    ) u_v_axis (
        .clk     (CLK),
        .rst     (RST),
        .step    (w_h_wrap),
        .count   (w_v_cnt),
        .wrap    (w_v_wrap),
        .in_sync (w_v_sync),
        .in_vis  (w_v_vis)
    );

    assign w_vis = w_h_vis && w_v_vis;

    // Counters sit at (0,0) exactly after reset or after a full-frame wrap,
    // so tracking those two events replaces a wide compare against zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_at_origin <= 1'b1;
        end else begin
            r_at_origin <= w_v_wrap;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HSYNC_Sig       <= ~SYNC_POL;
            VSYNC_Sig       <= ~SYNC_POL;
            Column_Addr_Sig <= '0;
            Row_Addr_Sig    <= '0;
            Ready_Sig       <= 1'b0;
            Frame_Start_Sig <= 1'b0;
        end else begin
            HSYNC_Sig       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            VSYNC_Sig       <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            Column_Addr_Sig <= w_vis ? w_h_cnt : '0;
            Row_Addr_Sig    <= w_vis ? w_v_cnt : '0;
            Ready_Sig       <= w_vis;
            Frame_Start_Sig <= r_at_origin;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic r_frame_seen;

    // The first frame start after reset only arms the counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_seen  <= 1'b0;
            Frame_Cnt_Sig <= '0;
        end else if (r_at_origin) begin
            r_frame_seen <= 1'b1;
            if (r_frame_seen) begin
                Frame_Cnt_Sig <= Frame_Cnt_Sig + 8'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Scoreboard bench: full-size and shrunk-timing generators against
//            an arithmetic raster model, with random reset pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    // Shrunk geometry keeps whole frames (and 258 of them) inside the run budget
    localparam int c_BHV = 8, c_BHF = 2, c_BHS = 3, c_BHB = 3;
    localparam int c_BVV = 4, c_BVF = 1, c_BVS = 2, c_BVB = 1;
    localparam int c_B_FRAME = (c_BHV + c_BHF + c_BHS + c_BHB) * (c_BVV + c_BVF + c_BVS + c_BVB);

    typedef struct {
        logic        hs;
        logic        vs;
        logic        rdy;
        logic        fs;
        logic [10:0] col;
        logic [10:0] row;
        logic [7:0]  fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_hs, a_vs, a_rdy, a_fs, b_hs, b_vs, b_rdy, b_fs;
    logic [10:0] a_col, a_row, b_col, b_row;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0]  a_fc, b_fc;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   idx    = 0;

    int   a_pix    = 0;
    int   n_rise   = 0;
    int   hs_width = 0;
    int   rise_at[2];
    logic a_hs_prev = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut_a (
        .CLK             (clk),
        .RST             (rst),
        .HSYNC_Sig       (a_hs),
        .VSYNC_Sig       (a_vs),
        .Column_Addr_Sig (a_col),
        .Row_Addr_Sig    (a_row),
        .Ready_Sig       (a_rdy),
        .Frame_Start_Sig (a_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .Frame_Cnt_Sig (a_fc)
`endif
    );

    vga_sync_gen #(
        .H_VIS (c_BHV), .H_FP (c_BHF), .H_SYNC (c_BHS), .H_BP (c_BHB),
        .V_VIS (c_BVV), .V_FP (c_BVF), .V_SYNC (c_BVS), .V_BP (c_BVB),
        .SYNC_POL (1'b0)
    ) u_dut_b (
        .CLK             (clk),
        .RST             (rst),
        .HSYNC_Sig       (b_hs),
        .VSYNC_Sig       (b_vs),
        .Column_Addr_Sig (b_col),
        .Row_Addr_Sig    (b_row),
        .Ready_Sig       (b_rdy),
        .Frame_Start_Sig (b_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .Frame_Cnt_Sig (b_fc)
`endif
    );

    // Output expected after the edge that consumes pixel p (p counts from 0 after reset)
    function automatic exp_t model(input bit in_rst, input int p,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input bit pol);
        exp_t e;
        int   ht, vt, h, v;
        bit   vis;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (in_rst) begin
            e.hs = ~pol; e.vs = ~pol; e.rdy = 1'b0; e.fs = 1'b0;
            e.col = '0;  e.row = '0;  e.fc = '0;
            return e;
        end
        h     = p % ht;
        v     = (p / ht) % vt;
        vis   = (h < hv) && (v < vv);
        e.hs  = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
        e.vs  = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
        e.rdy = vis;
        e.col = vis ? 11'(h) : 11'd0;
        e.row = vis ? 11'(v) : 11'd0;
        e.fs  = (h == 0) && (v == 0);
        e.fc  = 8'((p / (ht * vt)) % 256);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r);
        @(negedge clk);
        rst = r;
        qa.push_back(model(r, idx, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1));
        qb.push_back(model(r, idx, c_BHV, c_BHF, c_BHS, c_BHB, c_BVV, c_BVF, c_BVS, c_BVB, 1'b0));
        if (r) idx = 0;
        else   idx++;
    endtask

    // Monitor: one scoreboard entry per clock, compared just after the edge
    initial begin
        exp_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a_hsync", 32'(a_hs),  32'(ea.hs));
                chk("a_vsync", 32'(a_vs),  32'(ea.vs));
                chk("a_ready", 32'(a_rdy), 32'(ea.rdy));
                chk("a_fstart",32'(a_fs),  32'(ea.fs));
                chk("a_col",   32'(a_col), 32'(ea.col));
                chk("a_row",   32'(a_row), 32'(ea.row));
                chk("b_hsync", 32'(b_hs),  32'(eb.hs));
                chk("b_vsync", 32'(b_vs),  32'(eb.vs));
                chk("b_ready", 32'(b_rdy), 32'(eb.rdy));
                chk("b_fstart",32'(b_fs),  32'(eb.fs));
                chk("b_col",   32'(b_col), 32'(eb.col));
                chk("b_row",   32'(b_row), 32'(eb.row));
`ifdef VGA_SYNC_FRAME_CNT_EN
                chk("a_fcnt",  32'(a_fc),  32'(ea.fc));
                chk("b_fcnt",  32'(b_fc),  32'(eb.fc));
`endif
            end
            // Independent hsync measurement on the full-size instance
            if (a_fs === 1'b1) a_pix = 0;
            else               a_pix++;
            if (a_hs === 1'b1 && a_hs_prev === 1'b0 && n_rise < 2) begin
                rise_at[n_rise] = a_pix;
                n_rise++;
            end
            if (a_hs === 1'b1 && n_rise == 1) hs_width++;
            a_hs_prev = a_hs;
        end
    end

    initial begin
        int run_len, rst_len;
        repeat (3) step(1'b1);
        repeat (2200) step(1'b0);
        chk("hs_rise_count", 32'(n_rise), 32'd2);
        if (n_rise == 2) begin
            chk("hs_rise_pos",   32'(rise_at[0]), 32'd840);
            chk("hs_width",      32'(hs_width), 32'd128);
            chk("line_period",   32'(rise_at[1] - rise_at[0]), 32'd1056);
        end

        for (int k = 0; k < 20; k++) begin
            run_len = $urandom_range(900, 1);
            rst_len = $urandom_range(3, 1);
            repeat (run_len) step(1'b0);
            repeat (rst_len) step(1'b1);
        end

        step(1'b1);
        repeat (258 * c_B_FRAME + 40) step(1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
